// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the CPU memory-port arbiter.
// Bus widths follow the project-wide DataWidth define; 32 bits when it is absent.
`ifndef DataWidth
`define DataWidth 32
`endif

package mem_bus_arbiter_pkg;

  localparam int DW   = `DataWidth;
  localparam int AW   = `DataWidth;
  localparam int WD_W = 8;

  localparam logic [3:0] SEL_ALL = 4'hF;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_IF   = 2'd1;
  localparam logic [1:0] ARB_MEM  = 2'd2;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    sel;
  } bus_cmd_t;

  localparam bus_cmd_t BUS_CMD_NONE = '0;

  // Instruction fetches are always full-word reads.
  function automatic bus_cmd_t if_cmd(input logic [AW-1:0] addr);
    bus_cmd_t c;
    c.we    = 1'b0;
    c.addr  = addr;
    c.wdata = '0;
    c.sel   = SEL_ALL;
    return c;
  endfunction

  function automatic bus_cmd_t mem_cmd(input logic we, input logic [AW-1:0] addr,
                                       input logic [DW-1:0] wdata, input logic [3:0] sel);
    bus_cmd_t c;
    c.we    = we;
    c.addr  = addr;
    c.wdata = wdata;
    c.sel   = sel;
    return c;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_watchdog.sv
// Bus watchdog: counts unacknowledged transfer cycles and flags when TIMEOUT is reached.
module bus_watchdog
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam logic [WD_W-1:0] LIMIT = WD_W'(TIMEOUT);

  logic [WD_W-1:0] cnt;

  assign timeout = (cnt == LIMIT);

  // Holds at LIMIT so a TIMEOUT of 255 never wraps back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !timeout) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single external memory port between the IF and MEM pipeline stages,
// MEM-first with a starvation limit for IF and a watchdog on unacknowledged transfers.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  output logic          if_err,

  input  logic          mem_req,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  input  logic [3:0]    mem_sel,
  output logic          mem_ack,
  output logic [DW-1:0] mem_rdata,
  output logic          mem_err,

  output logic          stall_if,
  output logic          stall_mem,

  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  output logic [3:0]    bus_sel,
  input  logic          bus_ack,
  input  logic [DW-1:0] bus_rdata
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [1:0] state;
  logic [3:0] starve_cnt;
  bus_cmd_t   cmd;
  logic       xfer;
  logic       grant_if;
  logic       grant_mem;
  logic       wd_timeout;
  logic       done;
  logic       expire;

  assign xfer = (state != ARB_IDLE);

  always_comb begin
    // NOTE: both grants get a default first so no path leaves them unassigned (no latch).
    grant_if  = 1'b0;
    grant_mem = 1'b0;
    if (state == ARB_IDLE) begin
      if (mem_req && !(if_req && starve_cnt == STARVE_MAX)) begin
        grant_mem = 1'b1;
      end else if (if_req) begin
        grant_if = 1'b1;
      end
    end
  end

  // A slave ack in the expiry cycle wins over the watchdog.
  assign done   = xfer && (bus_ack || wd_timeout);
  assign expire = xfer && wd_timeout && !bus_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ARB_IDLE;
      bus_req <= 1'b0;
      cmd     <= BUS_CMD_NONE;
    end else if (grant_mem) begin
      state   <= ARB_MEM;
      bus_req <= 1'b1;
      cmd     <= mem_cmd(mem_we, mem_addr, mem_wdata, mem_sel);
    end else if (grant_if) begin
      state   <= ARB_IF;
      bus_req <= 1'b1;
      cmd     <= if_cmd(if_addr);
    end else if (done) begin
      state   <= ARB_IDLE;
      bus_req <= 1'b0;
      cmd     <= BUS_CMD_NONE;
    end
  end

  // Consecutive MEM wins while IF is waiting; any cycle without an IF request forgives them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!if_req || grant_if) begin
      starve_cnt <= '0;
    end else if (grant_mem && starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (grant_if || grant_mem),
    .en      (xfer && !bus_ack),
    .timeout (wd_timeout)
  );

  assign bus_we    = cmd.we;
  assign bus_addr  = cmd.addr;
  assign bus_wdata = cmd.wdata;
  assign bus_sel   = cmd.sel;

  assign if_ack   = (state == ARB_IF) && done;
  assign if_err   = (state == ARB_IF) && expire;
  assign if_rdata = (state == ARB_IF && bus_ack) ? bus_rdata : '0;

  assign mem_ack   = (state == ARB_MEM) && done;
  assign mem_err   = (state == ARB_MEM) && expire;
  assign mem_rdata = (state == ARB_MEM && bus_ack && !cmd.we) ? bus_rdata : '0;

  assign stall_if  = if_req && !if_ack;
  assign stall_mem = mem_req && !mem_ack;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized traffic,
// compared every cycle against a transaction-level reference model.
module tb_mem_bus_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int TIMEOUT      = 8;
  localparam int NEVER        = 1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, mem_req, mem_we, bus_ack;
  logic [31:0] if_addr, mem_addr, mem_wdata, bus_rdata;
  logic [3:0]  mem_sel;
  logic        if_ack, if_err, mem_ack, mem_err, stall_if, stall_mem;
  logic [31:0] if_rdata, mem_rdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_sel;

  mem_bus_arbiter #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .TIMEOUT      (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .if_err    (if_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_sel   (mem_sel),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .mem_err   (mem_err),
    .stall_if  (stall_if),
    .stall_mem (stall_mem),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_sel   (bus_sel),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: who owns the bus, what it asked for, how long it has waited.
  typedef enum int {OWN_NONE, OWN_IF, OWN_MEM} owner_e;
  owner_e      m_owner;
  logic        m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_sel;
  int          m_wait, m_streak, ack_plan;
  logic        e_fin, e_if_ack, e_if_err, e_mem_ack, e_mem_err;
  logic [31:0] e_if_rdata, e_mem_rdata;

  int          forced_plan = -1;
  bit          idle_noise  = 1'b0;
  bit          use_fixed   = 1'b0;
  logic [31:0] fixed_rdata = '0;

  logic        o_if_ack, o_if_err, o_mem_ack, o_mem_err, o_bus_req, o_bus_we;
  logic [31:0] o_if_rdata, o_mem_rdata;
  logic [3:0]  o_bus_sel;
  int          busreq_cycles;
  logic [31:0] grant_q[$];

  task automatic model_reset();
    m_owner  = OWN_NONE;
    m_we     = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
    m_sel    = '0;
    m_wait   = 0;
    m_streak = 0;
    ack_plan = NEVER;
  endtask

  task automatic compute_expect();
    logic tmo;
    tmo         = (m_owner != OWN_NONE) && (m_wait == TIMEOUT) && !bus_ack;
    e_fin       = (m_owner != OWN_NONE) && (bus_ack || m_wait == TIMEOUT);
    e_if_ack    = (m_owner == OWN_IF) && e_fin;
    e_if_err    = (m_owner == OWN_IF) && tmo;
    e_if_rdata  = (m_owner == OWN_IF && bus_ack) ? bus_rdata : 32'h0;
    e_mem_ack   = (m_owner == OWN_MEM) && e_fin;
    e_mem_err   = (m_owner == OWN_MEM) && tmo;
    e_mem_rdata = (m_owner == OWN_MEM && bus_ack && !m_we) ? bus_rdata : 32'h0;
  endtask

  task automatic start_xfer();
    int r;
    m_wait = 0;
    if (forced_plan >= 0) begin
      ack_plan = forced_plan;
    end else begin
      r = $urandom_range(0, 9);
      ack_plan = (r <= 5) ? r % 4 : (r == 6) ? TIMEOUT : (r == 7) ? NEVER : 1;
    end
  endtask

  task automatic model_advance();
    if (m_owner == OWN_NONE) begin
      if (mem_req && !(if_req && m_streak >= STARVE_LIMIT)) begin
        m_owner = OWN_MEM;
        m_we    = mem_we;
        m_addr  = mem_addr;
        m_wdata = mem_wdata;
        m_sel   = mem_sel;
        if (if_req) m_streak = (m_streak < STARVE_LIMIT) ? m_streak + 1 : STARVE_LIMIT;
        start_xfer();
      end else if (if_req) begin
        m_owner  = OWN_IF;
        m_we     = 1'b0;
        m_addr   = if_addr;
        m_wdata  = '0;
        m_sel    = 4'hF;
        m_streak = 0;
        start_xfer();
      end
    end else if (e_fin) begin
      m_owner = OWN_NONE;
      m_we    = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
      m_sel   = '0;
    end else begin
      m_wait++;
    end
    if (!if_req) m_streak = 0;
  endtask

  // One clock: drive slave, check at negedge, advance model at posedge.
  task automatic cycle();
    if (m_owner != OWN_NONE) bus_ack = (m_wait == ack_plan);
    else bus_ack = idle_noise && ($urandom_range(0, 3) == 0);
    bus_rdata = use_fixed ? fixed_rdata : $urandom();
    @(negedge clk);
    compute_expect();
    check("bus_ctl", {bus_req, bus_we, bus_sel}, {m_owner != OWN_NONE, m_we, m_sel});
    check("bus_addr", bus_addr, m_addr);
    check("bus_wdata", bus_wdata, m_wdata);
    check("if_resp", {if_ack, if_err, stall_if}, {e_if_ack, e_if_err, if_req && !e_if_ack});
    check("if_rdata", if_rdata, e_if_rdata);
    check("mem_resp", {mem_ack, mem_err, stall_mem}, {e_mem_ack, e_mem_err, mem_req && !e_mem_ack});
    check("mem_rdata", mem_rdata, e_mem_rdata);
    o_if_ack    = if_ack;
    o_if_err    = if_err;
    o_if_rdata  = if_rdata;
    o_mem_ack   = mem_ack;
    o_mem_err   = mem_err;
    o_mem_rdata = mem_rdata;
    o_bus_req   = bus_req;
    o_bus_we    = bus_we;
    o_bus_sel   = bus_sel;
    if (bus_req) busreq_cycles++;
    if (bus_req && m_owner != OWN_NONE && m_wait == 0) grant_q.push_back(bus_addr);
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic run_until_mem_ack(input int limit);
    for (int i = 0; i < limit; i++) begin
      cycle();
      if (o_mem_ack) break;
    end
    check("mem_ack_seen", o_mem_ack, 1'b1);
    mem_req = 1'b0;
  endtask

  task automatic run_until_if_ack(input int limit);
    for (int i = 0; i < limit; i++) begin
      cycle();
      if (o_if_ack) break;
    end
    check("if_ack_seen", o_if_ack, 1'b1);
    if_req = 1'b0;
  endtask

  task automatic rand_requests();
    if (!if_req || o_if_ack) begin
      if_req  = ($urandom_range(0, 2) != 0);
      if_addr = $urandom();
    end
    if (!mem_req || o_mem_ack) begin
      mem_req   = ($urandom_range(0, 2) != 0);
      mem_we    = $urandom_range(0, 1);
      mem_addr  = $urandom();
      mem_wdata = $urandom();
      mem_sel   = 4'($urandom_range(0, 15));
    end
  endtask

  initial begin
    #300000;
    $display("FAIL global_time_limit: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; mem_sel = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    o_if_ack = 1'b0; o_mem_ack = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    if_req = 1'b1; mem_req = 1'b1;
    #1;
    check("rst_bus_ctl", {bus_req, bus_we, bus_sel}, 6'h0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_wdata", bus_wdata, 32'h0);
    check("rst_if_resp", {if_ack, if_err, if_rdata}, 34'h0);
    check("rst_mem_resp", {mem_ack, mem_err, mem_rdata}, 34'h0);
    check("rst_stall", {stall_if, stall_mem}, 2'b11);
    if_req = 1'b0; mem_req = 1'b0; bus_ack = 1'b0;
    rst_n = 1'b1;

    // MEM write with two slave wait states.
    forced_plan = 2;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h100; mem_wdata = 32'hDEADBEEF; mem_sel = 4'b0011;
    busreq_cycles = 0;
    run_until_mem_ack(20);
    check("t1_busreq_cycles", busreq_cycles, 3);
    check("t1_err", o_mem_err, 1'b0);
    cycle();

    // Both requesting continuously, zero-wait slave.
    forced_plan = 0;
    grant_q.delete();
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100;
    if_req = 1'b1; if_addr = 32'h400;
    for (int i = 0; i < 40 && grant_q.size() < 6; i++) cycle();
    check("t2_grant_count", grant_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      logic [31:0] want;
      want = (i == 4) ? 32'h400 : 32'h100;
      check("t2_grant_order", (i < grant_q.size()) ? grant_q[i] : 32'hFFFF_FFFF, want);
    end
    mem_req = 1'b0; if_req = 1'b0;
    repeat (3) cycle();

    // IF fetch returning known data.
    forced_plan = 1;
    use_fixed = 1'b1; fixed_rdata = 32'h3C011234;
    if_req = 1'b1; if_addr = 32'h400;
    run_until_if_ack(20);
    check("t3_rdata", o_if_rdata, 32'h3C011234);
    check("t3_we_sel", {o_bus_we, o_bus_sel}, {1'b0, 4'hF});
    cycle();

    // Slave never answers: watchdog abort.
    forced_plan = NEVER;
    fixed_rdata = 32'hFFFF_FFFF;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h200;
    busreq_cycles = 0;
    run_until_mem_ack(30);
    check("t4_err", o_mem_err, 1'b1);
    check("t4_rdata", o_mem_rdata, 32'h0);
    check("t4_busreq_cycles", busreq_cycles, TIMEOUT + 1);
    cycle();
    check("t4_idle_after", o_bus_req, 1'b0);

    // Slave ack coincides with watchdog expiry.
    forced_plan = TIMEOUT;
    fixed_rdata = 32'h1234_5678;
    mem_req = 1'b1; mem_addr = 32'h300;
    busreq_cycles = 0;
    run_until_mem_ack(30);
    check("t5_err", o_mem_err, 1'b0);
    check("t5_rdata", o_mem_rdata, 32'h1234_5678);
    check("t5_busreq_cycles", busreq_cycles, TIMEOUT + 1);
    cycle();
    use_fixed = 1'b0;

    // Asynchronous reset in the middle of a MEM transfer.
    forced_plan = NEVER;
    mem_req = 1'b1; mem_addr = 32'h500;
    repeat (2) cycle();
    bus_ack = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_bus_req", bus_req, 1'b0);
    check("rst_mid_acks", {mem_ack, mem_err, if_ack, if_err}, 4'h0);
    check("rst_mid_stall", stall_mem, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    mem_req = 1'b0;
    forced_plan = 0;
    if_req = 1'b1; if_addr = 32'h600;
    run_until_if_ack(10);
    cycle();

    // Randomized traffic.
    forced_plan = -1;
    idle_noise = 1'b1;
    o_if_ack = 1'b0; o_mem_ack = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      rand_requests();
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the CPU's single external memory port between the instruction-fetch stage (IF) and the memory-access stage (MEM). Requests are arbitrated, the winner's address/data are held on the bus until the slave acknowledges, and a per-requester ack/stall pair lets each pipeline stage freeze until its access completes. MEM has priority, with a starvation limit that guarantees IF forward progress. A bus watchdog ends any transfer the slave never acknowledges.

## Interface
- `STARVE_LIMIT`, 4: consecutive MEM grants while IF waits before IF is forced through (1..15).
- `TIMEOUT`, 255: cycles without `bus_ack` before a transfer is aborted (1..255).
- `clk` in 1: clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `if_req` in 1 / `if_addr` in 32: fetch request, word address. Held until `if_ack`.
- `if_ack` out 1 / `if_rdata` out 32 / `if_err` out 1: completion pulse, read data, timeout flag (valid with `if_ack`).
- `mem_req` in 1 / `mem_we` in 1 / `mem_addr` in 32 / `mem_wdata` in 32 / `mem_sel` in 4: data request, byte-lane select. Held until `mem_ack`.
- `mem_ack` out 1 / `mem_rdata` out 32 / `mem_err` out 1: as for IF.
- `stall_if` out 1, `stall_mem` out 1: `X_req && !X_ack`.
- `bus_req` out 1 / `bus_we` out 1 / `bus_addr` out 32 / `bus_wdata` out 32 / `bus_sel` out 4: registered bus master outputs.
- `bus_ack` in 1 / `bus_rdata` in 32: slave completion and read data.

## Operation
- States: IDLE, IF_XFER, MEM_XFER.
- IDLE: only `mem_req` -> MEM_XFER; only `if_req` -> IF_XFER; both -> MEM_XFER unless `starve_cnt == STARVE_LIMIT`, then IF_XFER; none -> stay.
- On a grant, register the winner's fields onto `bus_*` and set `bus_req=1`. IF grants drive `bus_we=0`, `bus_sel=4'hF`, `bus_wdata=0`. Fields are latched; requester changes mid-transfer are ignored.
- In XFER, when `bus_ack=1`:
  - combinationally assert the owner's ack;
  - pass `bus_rdata` to the owner's rdata (zero for writes);
  - clear `bus_req` and all `bus_*` to 0 and go to IDLE.
- Non-owner ack and rdata are always 0.
- `starve_cnt` (4 bits):
  - increments on a MEM grant while `if_req=1`, saturating at `STARVE_LIMIT`;
  - clears on an IF grant;
  - clears in any cycle with `if_req=0`.
- Watchdog: `wd_cnt` clears on every grant and increments each XFER cycle without `bus_ack`. When it reaches `TIMEOUT`:
  - pulse the owner's ack together with its err, with rdata = 0;
  - drop `bus_req` and go to IDLE.
  - A `bus_ack` in that same cycle wins: normal completion, err=0.
- A `bus_ack` in IDLE is ignored.

## Timing
- Reset values: state IDLE, counters 0, every `bus_*` output 0. `if_*`/`mem_*` ack, err and rdata are 0. Each stall equals its `req` input.
- Reset mid-transfer: `bus_req` falls asynchronously, with no ack or err to either requester.
- Minimum latency: request seen in cycle 0 -> `bus_req` in cycle 1 -> ack in cycle 1 if the slave is zero-wait.
- The cycle after any ack is always IDLE, so back-to-back transfers are 2 cycles apart. Requesters must deassert or replace their request in the cycle after their ack.
- `bus_*` outputs stay stable from grant until completion.
- Ack and err are single-cycle pulses.

## Structure
- Shared package: state encoding (`ARB_IDLE`, `ARB_IF`, `ARB_MEM`), the 4-bit `SEL_ALL` constant, and data/address widths taken from the existing `DataWidth` define.
- One natural sub-module: `bus_watchdog` (8-bit counter with clear/enable inputs and a `timeout` output).

## Test plan
- Only `mem_req`, write to 0x100 with data 0xDEADBEEF and sel 4'b0011; slave acks after 2 wait cycles -> `bus_req` high for 3 cycles with fields stable, `mem_ack` in the third, `stall_mem` high until then.
- Both requesting continuously with zero-wait slave -> grant order MEM, MEM, MEM, MEM, IF, MEM… (STARVE_LIMIT=4), with no IF ack before the 5th grant.
- Only `if_req` at 0x400, slave returns 0x3C011234 -> `if_rdata`=0x3C011234 with `if_ack`; `bus_we`=0, `bus_sel`=4'hF.
- Slave never acks, TIMEOUT=8 -> `mem_ack` and `mem_err` pulse together 8 cycles after grant, `mem_rdata`=0, next cycle IDLE.
- `rst_n` asserted mid-MEM_XFER -> `bus_req` drops immediately and no ack fires. After release, a pending `if_req` is granted normally with `starve_cnt`=0.
- `bus_ack` on the same cycle the watchdog expires -> normal completion, err=0, rdata passed through.
